// File: rtl/store_buffer_coalesce.sv
// Committed-store FIFO between commit and the data-memory arbiter, with optional
// write-combining into the youngest entry and byte-granular load forwarding.
module store_buffer_coalesce #(
    parameter int unsigned SB_DEPTH  = 3,
    parameter int unsigned NUM_BYTES = 4,
    parameter bit          COALESCE  = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push_valid,
    output logic                   o_push_ready,
    input  logic [31:0]            i_push_addr,
    input  logic [NUM_BYTES-1:0]   i_push_wmask,
    input  logic [8*NUM_BYTES-1:0] i_push_wdata,
    output logic                   o_dmem_w_rqst,
    output logic [31:0]            o_dmem_w_addr,
    output logic [NUM_BYTES-1:0]   o_dmem_w_wmask,
    output logic [8*NUM_BYTES-1:0] o_dmem_w_wdata,
    input  logic                   i_dmem_w_ack,
    input  logic [31:0]            i_ld_addr,
    input  logic [NUM_BYTES-1:0]   i_ld_rmask,
    output logic [8*NUM_BYTES-1:0] o_fwd_data,
    output logic [NUM_BYTES-1:0]   o_fwd_hit_mask,
    output logic                   o_fwd_full,
    output logic [SB_DEPTH:0]      o_sb_count,
    output logic                   o_sb_full,
    output logic                   o_sb_empty
);

    localparam int unsigned       NUM       = 2 ** SB_DEPTH;
    localparam int unsigned       DW        = 8 * NUM_BYTES;
    localparam int unsigned       OFF       = $clog2(NUM_BYTES);
    localparam logic [31:0]       LINE_MASK = ~((32'd1 << OFF) - 32'd1);
    localparam logic [SB_DEPTH:0] NUM_CNT   = (SB_DEPTH + 1)'(NUM);

    logic [NUM-1:0]       r_valid;
    logic [31:0]          r_addr [NUM];
    logic [NUM_BYTES-1:0] r_mask [NUM];
    logic [DW-1:0]        r_data [NUM];
    logic [SB_DEPTH-1:0]  r_head;
    logic [SB_DEPTH-1:0]  r_tail;
    logic [SB_DEPTH:0]    r_count;

    logic [31:0]         w_push_line;
    logic [31:0]         w_ld_line;
    logic [SB_DEPTH-1:0] w_young;
    logic [SB_DEPTH-1:0] w_idx;
    logic [DW-1:0]       w_lane_bits;
    logic                w_not_full;
    logic                w_pop;
    logic                w_can_merge;
    logic                w_merge;
    logic                w_alloc;

    assign w_push_line = i_push_addr & LINE_MASK;
    assign w_ld_line   = i_ld_addr & LINE_MASK;
    assign w_young     = r_head - SB_DEPTH'(1);
    assign w_not_full  = (r_count != NUM_CNT);
    assign w_pop       = i_dmem_w_ack && o_dmem_w_rqst;

    // The tail entry may be handed to the arbiter at any moment, so it is never merged into.
    assign w_can_merge = COALESCE && r_valid[w_young] && (w_young != r_tail) &&
                         (r_addr[w_young] == w_push_line);

    assign o_push_ready = w_can_merge || w_not_full || w_pop;
    assign w_merge      = i_push_valid && w_can_merge;
    assign w_alloc      = i_push_valid && !w_can_merge && (w_not_full || w_pop);

    always_comb begin
        w_lane_bits = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            w_lane_bits[8*b +: 8] = {8{i_push_wmask[b]}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM; i++) begin
                r_addr[i] <= '0;
                r_mask[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_tail] <= 1'b0;
                r_mask[r_tail]  <= '0;
                r_tail          <= r_tail + SB_DEPTH'(1);
            end
            if (w_merge) begin
                r_mask[w_young] <= r_mask[w_young] | i_push_wmask;
                r_data[w_young] <= (r_data[w_young] & ~w_lane_bits) |
                                   (i_push_wdata & w_lane_bits);
            end
            // When full with a same-cycle pop, head == tail and this write reuses the freed slot.
            if (w_alloc) begin
                r_valid[r_head] <= 1'b1;
                r_addr[r_head]  <= w_push_line;
                r_mask[r_head]  <= i_push_wmask;
                r_data[r_head]  <= i_push_wdata & w_lane_bits;
                r_head          <= r_head + SB_DEPTH'(1);
            end
            if (w_alloc && !w_pop) begin
                r_count <= r_count + (SB_DEPTH + 1)'(1);
            end else if (!w_alloc && w_pop) begin
                r_count <= r_count - (SB_DEPTH + 1)'(1);
            end
        end
    end

    assign o_dmem_w_rqst = (r_count != '0);

    always_comb begin
        o_dmem_w_addr  = '0;
        o_dmem_w_wmask = '0;
        o_dmem_w_wdata = '0;
        if (o_dmem_w_rqst) begin
            o_dmem_w_addr  = r_addr[r_tail];
            o_dmem_w_wmask = r_mask[r_tail];
            o_dmem_w_wdata = r_data[r_tail];
        end
    end

    // Walk oldest to youngest so younger hits overwrite older ones lane by lane.
    always_comb begin
        o_fwd_data     = '0;
        o_fwd_hit_mask = '0;
        w_idx          = '0;
        for (int i = 0; i < NUM; i++) begin
            w_idx = r_tail + SB_DEPTH'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == w_ld_line)) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (r_mask[w_idx][b]) begin
                        o_fwd_hit_mask[b]     = 1'b1;
                        o_fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign o_fwd_full = ((o_fwd_hit_mask & i_ld_rmask) == i_ld_rmask) && (i_ld_rmask != '0);

    assign o_sb_count = r_count;
    assign o_sb_full  = (r_count == NUM_CNT);
    assign o_sb_empty = (r_count == '0);

endmodule
